bproc_update_sched: RTL and testbench

Clocked scheduler that shares the branch-process update resources (predictor tables and correct-PC register) between the front-end learning commit stream and the back-end resolution stream. It accepts one request per transaction from either source and routes it: an all-zero payload becomes a table write, a non-zero payload becomes a correct-PC load. It sequences the multi-cycle table write, tracks in-flight predicted branches, and throttles the front end. It sits between the predict/learn stage and the table/correct storage of the branch-process block.

---
 rtl/bproc_pkg.sv | 18 +
 rtl/bproc_sched_arb.sv | 49 ++++
 rtl/bproc_update_sched.sv | 147 ++++++++++++++
 tb/tb_bproc_update_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bproc_pkg.sv
// Shared types and constants for the branch-process update scheduler.
package bproc_pkg;

  localparam int BPROC_DW = 33;
  localparam logic [BPROC_DW-1:0] BPROC_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TBL_BUSY = 2'd1,
    CORR     = 2'd2
  } bproc_state_e;

  // An all-zero payload is a learning commit that targets the predictor tables.
  function automatic logic bproc_is_commit(input logic [BPROC_DW-1:0] d);
    return d == BPROC_ZERO;
  endfunction

endpackage

// File: rtl/bproc_sched_arb.sv
// Eligibility and grant logic for the update scheduler; BPROC_SCHED_RR_EN
// selects round-robin arbitration instead of fixed back-over-prev priority.
module bproc_sched_arb
  import bproc_pkg::*;
#(
  parameter int MAX_PENDING = 8
) (
`ifdef BPROC_SCHED_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       i_idle,
  input  logic       i_prev_valid,
  input  logic       i_back_valid,
  input  logic [3:0] i_pending_cnt,
  output logic       o_gnt_prev,
  output logic       o_gnt_back
);

  localparam logic [3:0] MAXP = 4'(MAX_PENDING);

  logic w_elig_prev;
  logic w_elig_back;

  assign w_elig_back = i_idle & i_back_valid;
  assign w_elig_prev = i_idle & i_prev_valid & (i_pending_cnt < MAXP);

`ifdef BPROC_SCHED_RR_EN
  // r_last_back remembers which source won the previous grant; starts as back.
  logic r_last_back;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_back <= 1'b1;
    end else if (o_gnt_back | o_gnt_prev) begin
      r_last_back <= o_gnt_back;
    end
  end

  always_comb begin
    o_gnt_back = w_elig_back & (~w_elig_prev | ~r_last_back);
    o_gnt_prev = w_elig_prev & (~w_elig_back | r_last_back);
  end
`else
  assign o_gnt_back = w_elig_back;
  assign o_gnt_prev = w_elig_prev & ~w_elig_back;
`endif

endmodule

// File: rtl/bproc_update_sched.sv
// Shares table/correct-PC update resources between the front-end learn stream
// and the back-end resolution stream. Optional macro: BPROC_SCHED_RR_EN.
module bproc_update_sched
  import bproc_pkg::*;
#(
  parameter int TBL_LAT     = 2,
  parameter int MAX_PENDING = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prev_valid,
  input  logic [BPROC_DW-1:0] prev_data,
  output logic                prev_ready,
  input  logic                back_valid,
  input  logic [BPROC_DW-1:0] back_data,
  output logic                back_ready,
  output logic                tbl_fire,
  output logic                corr_fire,
  output logic [BPROC_DW-1:0] upd_data,
  output logic [3:0]          pending_cnt,
  output logic                underflow_err
);

  localparam int CW = (TBL_LAT > 1) ? $clog2(TBL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TBL_LAT - 1);

  bproc_state_e        r_state;
  bproc_state_e        w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                r_tbl_fire;
  logic                r_corr_fire;
  logic [BPROC_DW-1:0] r_upd_data;
  logic [3:0]          r_pending;
  logic                r_underflow;

  logic                w_idle;
  logic                w_gnt_prev;
  logic                w_gnt_back;
  logic                w_gnt;
  logic                w_commit;
  logic [BPROC_DW-1:0] w_gnt_data;
  logic [3:0]          w_pend_nxt;
  logic                w_uf_set;

  assign w_idle = (r_state == IDLE);

  bproc_sched_arb #(
    .MAX_PENDING(MAX_PENDING)
  ) u_arb (
`ifdef BPROC_SCHED_RR_EN
    .clk           (clk),
    .rst           (rst),
`endif
    .i_idle        (w_idle),
    .i_prev_valid  (prev_valid),
    .i_back_valid  (back_valid),
    .i_pending_cnt (r_pending),
    .o_gnt_prev    (w_gnt_prev),
    .o_gnt_back    (w_gnt_back)
  );

  assign w_gnt      = w_gnt_prev | w_gnt_back;
  assign w_gnt_data = w_gnt_back ? back_data : prev_data;
  assign w_commit   = bproc_is_commit(w_gnt_data);

  assign prev_ready = w_gnt_prev;
  assign back_ready = w_gnt_back;

  // The count is loaded with TBL_LAT-1 and the table stays busy until it has
  // been observed at zero, so the tables are held for exactly TBL_LAT cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_gnt) begin
          if (w_commit) begin
            w_state_nxt = TBL_BUSY;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = CORR;
          end
        end
      end
      TBL_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      CORR:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // In-flight branch tracking: prev adds, back commit retires, back flush clears.
  always_comb begin
    w_pend_nxt = r_pending;
    w_uf_set   = 1'b0;
    if (w_gnt_prev) begin
      w_pend_nxt = r_pending + 4'd1;
    end else if (w_gnt_back) begin
      if (w_commit) begin
        if (r_pending == 4'd0) begin
          w_uf_set = 1'b1;
        end else begin
          w_pend_nxt = r_pending - 4'd1;
        end
      end else begin
        w_pend_nxt = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_tbl_fire  <= 1'b0;
      r_corr_fire <= 1'b0;
      r_upd_data  <= '0;
      r_pending   <= 4'd0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tbl_fire  <= w_gnt & w_commit;
      r_corr_fire <= w_gnt & ~w_commit;
      if (w_gnt) begin
        r_upd_data <= w_gnt_data;
      end
      r_pending <= w_pend_nxt;
      if (w_uf_set) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign tbl_fire      = r_tbl_fire;
  assign corr_fire     = r_corr_fire;
  assign upd_data      = r_upd_data;
  assign pending_cnt   = r_pending;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_bproc_update_sched.sv
// Self-checking bench for bproc_update_sched: directed scenarios plus random
// traffic compared each cycle against a transaction-level model.
module tb_bproc_update_sched;
  import bproc_pkg::*;

  localparam int TBL_LAT     = 2;
  localparam int MAX_PENDING = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                prev_valid = 1'b0;
  logic [BPROC_DW-1:0] prev_data = '0;
  logic                prev_ready;
  logic                back_valid = 1'b0;
  logic [BPROC_DW-1:0] back_data = '0;
  logic                back_ready;
  logic                tbl_fire;
  logic                corr_fire;
  logic [BPROC_DW-1:0] upd_data;
  logic [3:0]          pending_cnt;
  logic                underflow_err;

  always #5 clk = ~clk;

  bproc_update_sched #(
    .TBL_LAT     (TBL_LAT),
    .MAX_PENDING (MAX_PENDING)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .prev_valid    (prev_valid),
    .prev_data     (prev_data),
    .prev_ready    (prev_ready),
    .back_valid    (back_valid),
    .back_data     (back_data),
    .back_ready    (back_ready),
    .tbl_fire      (tbl_fire),
    .corr_fire     (corr_fire),
    .upd_data      (upd_data),
    .pending_cnt   (pending_cnt),
    .underflow_err (underflow_err)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: the resource is free when no busy cycles remain.
  int                  m_busy = 0;
  int                  m_pend = 0;
  bit                  m_uf = 1'b0;
  bit                  m_tf = 1'b0;
  bit                  m_cf = 1'b0;
  bit                  m_last_back = 1'b1;
  logic [BPROC_DW-1:0] m_upd = '0;

  function automatic void m_grants(output bit gp, output bit gb);
    bit eb, ep;
    eb = (m_busy == 0) && (back_valid === 1'b1);
    ep = (m_busy == 0) && (prev_valid === 1'b1) && (m_pend < MAX_PENDING);
`ifdef BPROC_SCHED_RR_EN
    if (eb && ep) begin
      gb = !m_last_back;
      gp = m_last_back;
    end else begin
      gb = eb;
      gp = ep;
    end
`else
    gb = eb;
    gp = ep && !eb;
`endif
  endfunction

  initial begin : model_proc
    bit gp, gb;
    logic [BPROC_DW-1:0] d;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 0; m_pend = 0; m_uf = 0; m_tf = 0; m_cf = 0;
        m_last_back = 1'b1; m_upd = '0;
      end else begin
        m_grants(gp, gb);
        m_tf = 0;
        m_cf = 0;
        if (gp || gb) begin
          d = gb ? back_data : prev_data;
          m_upd = d;
          if (d == '0) begin
            m_tf = 1; m_busy = TBL_LAT;
          end else begin
            m_cf = 1; m_busy = 1;
          end
          if (gp) m_pend = m_pend + 1;
          else if (d == '0) begin
            if (m_pend == 0) m_uf = 1;
            else m_pend = m_pend - 1;
          end else m_pend = 0;
          m_last_back = gb;
        end else if (m_busy > 0) begin
          m_busy = m_busy - 1;
        end
      end
    end
  end

  initial begin : cmp_proc
    bit gp, gb;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        m_grants(gp, gb);
        chk("prev_ready", prev_ready, gp);
        chk("back_ready", back_ready, gb);
        chk("tbl_fire", tbl_fire, m_tf);
        chk("corr_fire", corr_fire, m_cf);
        chk("upd_data", upd_data, m_upd);
        chk("pending_cnt", pending_cnt, m_pend);
        chk("underflow_err", underflow_err, m_uf);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic logic [BPROC_DW-1:0] rnd_data();
    case ($urandom_range(0, 2))
      0:       return '0;
      1:       return {1'b0, 32'($urandom())};
      default: return {1'b1, 32'($urandom())};
    endcase
  endfunction

  initial begin : main
    bit reached;
    bit ap, ab;
    int np, nb;

    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    neg();
    chk("rst_tbl_fire", tbl_fire, 0);
    chk("rst_corr_fire", corr_fire, 0);
    chk("rst_upd_data", upd_data, 0);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_underflow", underflow_err, 0);
    chk("rst_prev_ready", prev_ready, 0);
    chk("rst_back_ready", back_ready, 0);
    neg();
    #1 rst = 1'b1;

    // Front-end correct-PC request.
    cyc(); prev_valid = 1'b1; prev_data = 33'h0_0000_1000;
    neg(); chk("t1_prev_ready", prev_ready, 1);
    cyc(); prev_valid = 1'b0; prev_data = '0;
    neg();
    chk("t1_corr_fire", corr_fire, 1);
    chk("t1_tbl_fire", tbl_fire, 0);
    chk("t1_upd_data", upd_data, 33'h0_0000_1000);
    chk("t1_pending", pending_cnt, 1);
    neg(); chk("t1_corr_once", corr_fire, 0);

    // Back commit, then a second commit held to measure the table occupancy.
    cyc(); back_valid = 1'b1; back_data = '0;
    neg(); chk("t2_back_ready_N", back_ready, 1);
    cyc();
    neg();
    chk("t2_tbl_fire", tbl_fire, 1);
    chk("t2_pending", pending_cnt, 0);
    chk("t2_busy_N1", back_ready, 0);
    neg();
    chk("t2_tbl_once", tbl_fire, 0);
    chk("t2_busy_N2", back_ready, 0);
    neg(); chk("t2_ready_N3", back_ready, 1);
    cyc(); back_valid = 1'b0;
    neg();
    chk("t2_uf_pending", pending_cnt, 0);
    chk("t2_uf_set", underflow_err, 1);

    // Fill to the in-flight limit.
    cyc(); prev_valid = 1'b1; prev_data = 33'h0_0000_4000;
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      neg();
      if (pending_cnt == 4'd8) begin
        reached = 1'b1;
        break;
      end
    end
    chk("t3_reach8", reached, 1);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t3_stall_ready", prev_ready, 0);
      chk("t3_stall_pend", pending_cnt, 8);
    end

    // Misprediction flush releases the stall.
    cyc(); back_valid = 1'b1; back_data = 33'h1_0000_2000;
    neg();
    chk("t3_flush_back_ready", back_ready, 1);
    chk("t3_flush_prev_ready", prev_ready, 0);
    cyc(); back_valid = 1'b0; back_data = '0;
    neg();
    chk("t3_flush_pending", pending_cnt, 0);
    chk("t3_flush_corr", corr_fire, 1);
    chk("t3_flush_upd", upd_data, 33'h1_0000_2000);
    neg(); chk("t3_prev_resume", prev_ready, 1);
    cyc(); prev_valid = 1'b0;
    neg(); chk("t3_pending1", pending_cnt, 1);
    chk("t3_uf_sticky", underflow_err, 1);

    // Both sources continuously requesting.
    cyc();
    prev_valid = 1'b1; prev_data = 33'h0_0000_0010;
    back_valid = 1'b1; back_data = 33'h0_0000_0020;
    np = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      neg();
      if (prev_ready) np++;
      if (back_ready) nb++;
    end
`ifdef BPROC_SCHED_RR_EN
    chk("t4_rr_balance", ((np > nb) ? (np - nb) : (nb - np)) <= 1, 1);
    chk("t4_rr_prev_served", np > 0, 1);
`else
    chk("t4_prev_starved", np, 0);
    chk("t4_back_served", nb > 0, 1);
`endif
    cyc(); prev_valid = 1'b0; back_valid = 1'b0;
    repeat (3) neg();

    // Reset while the tables are busy.
    cyc(); back_valid = 1'b1; back_data = '0;
    neg();
    cyc(); back_valid = 1'b0;
    neg(); chk("t5_busy_tbl_fire", tbl_fire, 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_tbl_fire", tbl_fire, 0);
    chk("t5_rst_corr_fire", corr_fire, 0);
    chk("t5_rst_upd", upd_data, 0);
    chk("t5_rst_pending", pending_cnt, 0);
    chk("t5_rst_uf", underflow_err, 0);
    neg();
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t5_no_tbl", tbl_fire, 0);
      chk("t5_no_corr", corr_fire, 0);
    end

    // Random traffic; requests hold until accepted.
    for (int c = 0; c < 2000; c++) begin
      neg();
      ap = prev_valid && prev_ready;
      ab = back_valid && back_ready;
      cyc();
      if (!prev_valid || ap) begin
        prev_valid = ($urandom_range(0, 2) != 0);
        prev_data  = rnd_data();
      end
      if (!back_valid || ab) begin
        back_valid = ($urandom_range(0, 3) == 0);
        back_data  = rnd_data();
      end
    end
    cyc(); prev_valid = 1'b0; back_valid = 1'b0;
    repeat (4) neg();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
